signed_divider_seq: RTL and testbench
=====================================

Name: signed_divider_seq

Overview:
- Multi-cycle signed two's-complement integer divider. It is the inverse datapath of the Wallace-tree multiplier and shares the same operand/result conventions.
- Sits beside the multiplier in the CPU's mult/div unit and serves DIV instructions.
- Uses a radix-2 restoring algorithm: one quotient bit per clock on magnitudes, followed by a sign fix-up cycle.
- Quotient truncates toward zero. The remainder takes the sign of the dividend.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (must be >= 4; the bench also runs WIDTH=4)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
ctrl_DIV  input  1  start pulse; sampled only when not busy
data_operandA  input  WIDTH  signed dividend; sampled on the ctrl_DIV edge
data_operandB  input  WIDTH  signed divisor; sampled on the ctrl_DIV edge
data_result  output  WIDTH  signed quotient; held until the next completion
data_remainder  output  WIDTH  signed remainder; held until the next completion
data_exception  output  1  divide-by-zero or overflow flag for the last operation; held
data_resultRDY  output  1  single-cycle completion pulse
busy  output  1  high from the cycle after an accepted start until the cycle before data_resultRDY

Behaviour:
- Clock and reset:
  - One clock. reset_n is asynchronous and active-low; deassertion is used synchronously.
  - While reset_n=0: state=IDLE; data_result, data_remainder, data_exception, data_resultRDY, busy and all internal registers are 0.
- States: IDLE, BUSY, FIX.
  - data_resultRDY is a registered pulse asserted in the cycle after FIX; the FSM is back in IDLE during that cycle.
- IDLE:
  - If ctrl_DIV=1 at the edge, the FSM latches operand magnitudes, the quotient sign (signA^signB) and the remainder sign (signA).
  - If latched divisor==0: set exception, go to FIX.
  - Otherwise: clear the partial remainder, count=0, go to BUSY.
- BUSY:
  - Each edge performs one restoring step: shift {rem,quot} left by 1 and trial-subtract |B| from rem.
  - If the trial result is non-negative, commit the subtraction and set quot bit0=1; otherwise restore and set bit0=0.
  - After exactly WIDTH steps, go to FIX.
- FIX (one cycle):
  - Negate quot if the quotient sign is set; negate rem if the remainder sign is set.
  - Register both to the outputs, register data_exception, assert data_resultRDY next cycle, go to IDLE.
- Latency: ctrl_DIV high in cycle 0 -> data_resultRDY high in cycle WIDTH+2 (33+1 cycles for WIDTH=32). Divide-by-zero completes in cycle 2.
- Start pulse handling:
  - A start is accepted in the same cycle data_resultRDY is high.
  - ctrl_DIV while busy=1 is ignored; there is no queuing and the operands are not resampled.
- Arithmetic rules:
  - Magnitudes use WIDTH+1 internal bits so that |MIN| is representable.
  - The trial subtractor is WIDTH+1 bits wide.
- Divide by zero: data_result=0, data_remainder=0, data_exception=1.
- Overflow (A = MIN, B = -1): data_result=MIN (wrap), data_remainder=0, data_exception=1. It is detected at latch time; the iterations still run.
- All other operations: data_exception=0.
- Outputs change only on FIX completion. Previous results stay stable during BUSY.
- If reset_n asserts mid-operation, the operation is abandoned, all outputs clear asynchronously, and no data_resultRDY is produced.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE/BUSY/FIX);
  - the counter width function clog2(WIDTH+1);
  - constants for MIN_SIGNED(WIDTH).
- One combinational sub-module, div_step: it takes rem/quot/divisor and returns the next rem/quot for one restoring iteration.
- The top level holds the FSM, counter, sign bookkeeping and output registers.

Test Plan:
1. WIDTH=32: A=7, B=2 -> data_resultRDY exactly 34 cycles after the start cycle; result=3, remainder=1, exception=0.
2. WIDTH=32 sign cases:
   - A=-7, B=2 -> -3 rem -1.
   - A=7, B=-2 -> -3 rem 1.
   - A=-7, B=-2 -> 3 rem -1.
   - A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF rem 0.
3. Exceptions:
   - WIDTH=4: A=-8, B=-1 -> result=-8, rem=0, exception=1.
   - WIDTH=32: A=5, B=0 -> data_resultRDY in cycle 2, result=0, rem=0, exception=1.
4. Start handling, WIDTH=32:
   - Start 100/7, then pulse ctrl_DIV with A=1, B=1 at cycle 10 -> that pulse is ignored; result=14 rem 2 at cycle 34.
   - A start pulse in the RDY cycle is accepted.
5. Reset during BUSY: pull reset_n low at cycle 5 -> outputs read 0 immediately; no data_resultRDY follows. A new 9/3 afterwards gives 3 rem 0.
6. Exhaustive WIDTH=4 sweep of all 256 A/B pairs:
   - Compare against the truncating reference (A/B, A%B).
   - B=0 cases must show exception=1 and zeros.
   - A=-8, B=-1 must show exception=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Widest operand for which min_signed() can build its constant.
  localparam int MAX_WIDTH = 64;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] min_signed(input int w);
    return MAX_WIDTH'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/signed_divider_seq_step.sv
// One radix-2 restoring iteration on magnitudes: shift {rem,quot}, trial-subtract divisor.
module signed_divider_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             nonneg;

  // The extra top bit of the trial difference acts as the borrow-out.
  always_comb begin
    shifted   = {rem, quot[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    nonneg    = ~trial[WIDTH+1];
    rem_next  = nonneg ? trial[WIDTH:0] : shifted[WIDTH:0];
    quot_next = {quot[WIDTH-2:0], nonneg};
  end

endmodule

// File: rtl/signed_divider_seq.sv
// Multi-cycle signed divider: restoring iterations on magnitudes, then a sign fix-up cycle.
module signed_divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_signed(WIDTH));

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   divisor;
  logic             q_sign;
  logic             r_sign;
  logic             exc_pend;

  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quot_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;
  logic             start;
  logic             last_step;

  // |MIN| wraps back to MIN, which is the correct unsigned magnitude in WIDTH bits.
  always_comb begin
    a_mag  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    b_zero = (data_operandB == '0);
    ovf    = (data_operandA == MIN_VAL) && (data_operandB == '1);
  end

  signed_divider_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .rem_next  (rem_step),
    .quot_next (quot_step)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    last_step = (count == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (ctrl_DIV) begin
          start     = 1'b1;
          state_nxt = b_zero ? FIX : BUSY;
        end
      end
      BUSY:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Divide-by-zero loads a zero quotient so the fix-up cycle yields all-zero outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count          <= '0;
      rem            <= '0;
      quot           <= '0;
      divisor        <= '0;
      q_sign         <= 1'b0;
      r_sign         <= 1'b0;
      exc_pend       <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            divisor  <= {1'b0, b_mag};
            quot     <= b_zero ? '0 : a_mag;
            rem      <= '0;
            count    <= '0;
            q_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_sign   <= data_operandA[WIDTH-1];
            exc_pend <= b_zero | ovf;
          end
        end
        BUSY: begin
          rem   <= rem_step;
          quot  <= quot_step;
          count <= count + CW'(1);
        end
        FIX: begin
          data_result    <= q_sign ? -quot : quot;
          data_remainder <= r_sign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          data_exception <= exc_pend;
          data_resultRDY <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_signed_divider_seq.sv
// Scoreboard bench for signed_divider_seq at WIDTH=32 and an exhaustive WIDTH=4 sweep.
module tb_signed_divider_seq;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        rstn32, rstn4;
  logic        div32, div4;
  logic [31:0] opa32, opb32;
  logic [3:0]  opa4, opb4;
  logic [31:0] res32, rem32;
  logic [3:0]  res4, rem4;
  logic        exc32, rdy32, busy32;
  logic        exc4, rdy4, busy4;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp32[$];
  exp_t exp4[$];

  signed_divider_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(rstn32), .ctrl_DIV(div32),
    .data_operandA(opa32), .data_operandB(opb32),
    .data_result(res32), .data_remainder(rem32), .data_exception(exc32),
    .data_resultRDY(rdy32), .busy(busy32)
  );

  signed_divider_seq #(.WIDTH(4)) dut4 (
    .clock(clock), .reset_n(rstn4), .ctrl_DIV(div4),
    .data_operandA(opa4), .data_operandB(opb4),
    .data_result(res4), .data_remainder(rem4), .data_exception(exc4),
    .data_resultRDY(rdy4), .busy(busy4)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per completion pulse.
  always @(negedge clock) begin : mon32
    exp_t e;
    if (rdy32) begin
      if (exp32.size() == 0) checkOutput("spurious_rdy32", rdy32, 0);
      else begin
        e = exp32.pop_front();
        checkOutput("q32", res32, e.q);
        checkOutput("r32", rem32, e.r);
        checkOutput("e32", exc32, e.e);
        checkOutput("lat32", cyc, e.cyc);
      end
    end
  end

  always @(negedge clock) begin : mon4
    exp_t e;
    if (rdy4) begin
      if (exp4.size() == 0) checkOutput("spurious_rdy4", rdy4, 0);
      else begin
        e = exp4.pop_front();
        checkOutput("q4", res4, e.q);
        checkOutput("r4", rem4, e.r);
        checkOutput("e4", exc4, e.e);
        checkOutput("lat4", cyc, e.cyc);
      end
    end
  end

  task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, output int startCyc);
    exp_t   e;
    longint la, lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (b == 0) begin
      e.q = 0; e.r = 0; e.e = 1'b1; e.cyc = cyc + 2;
    end else begin
      e.q = 32'(la / lb);
      e.r = 32'(la % lb);
      e.e = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      e.cyc = cyc + 34;
    end
    startCyc = cyc;
    exp32.push_back(e);
    opa32 = a; opb32 = b; div32 = 1'b1;
    @(posedge clock); #1;
    div32 = 1'b0;
  endtask

  task automatic applyStimulus4(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 0; e.r = 0; e.e = 1'b1; e.cyc = cyc + 2;
    end else begin
      e.q = {28'b0, 4'(a / b)};
      e.r = {28'b0, 4'(a % b)};
      e.e = (a == -8) && (b == -1);
      e.cyc = cyc + 6;
    end
    exp4.push_back(e);
    opa4 = 4'(a); opb4 = 4'(b); div4 = 1'b1;
    @(posedge clock); #1;
    div4 = 1'b0;
  endtask

  // Returns inside the completion cycle so the next start lands in the RDY cycle.
  task automatic waitDone32();
    int n = 0;
    while (exp32.size() != 0 && n < 60) begin
      @(negedge clock); #1;
      n++;
    end
    checkOutput("drain32", exp32.size(), 0);
  endtask

  task automatic waitDone4();
    int n = 0;
    while (exp4.size() != 0 && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    checkOutput("drain4", exp4.size(), 0);
  endtask

  logic [31:0] signTab [5][2];

  initial begin
    int s;
    signTab[0] = '{32'd7, 32'd2};
    signTab[1] = '{-32'sd7, 32'd2};
    signTab[2] = '{32'd7, -32'sd2};
    signTab[3] = '{-32'sd7, -32'sd2};
    signTab[4] = '{32'h7FFF_FFFF, 32'd1};

    rstn32 = 1'b0; rstn4 = 1'b0;
    div32 = 1'b0; div4 = 1'b0;
    opa32 = '0; opb32 = '0; opa4 = '0; opb4 = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_q32", res32, 0);
    checkOutput("rst_r32", rem32, 0);
    checkOutput("rst_e32", exc32, 0);
    checkOutput("rst_rdy32", rdy32, 0);
    checkOutput("rst_busy32", busy32, 0);
    checkOutput("rst_busy4", busy4, 0);
    rstn32 = 1'b1; rstn4 = 1'b1;
    @(negedge clock); #1;

    // Basic and sign cases, each started in the previous RDY cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus32(signTab[i][0], signTab[i][1], s);
      checkOutput("busy32", busy32, 1);
      waitDone32();
    end

    applyStimulus32(32'd5, 32'd0, s);
    waitDone32();

    // A pulse mid-operation must be ignored and the old outputs must hold.
    applyStimulus32(32'd100, 32'd7, s);
    while (cyc != s + 10) begin
      @(posedge clock); #1;
    end
    opa32 = 32'd1; opb32 = 32'd1; div32 = 1'b1;
    checkOutput("hold_e32", exc32, 1);
    checkOutput("busy_ign32", busy32, 1);
    @(posedge clock); #1;
    div32 = 1'b0;
    waitDone32();

    // Reset during BUSY abandons the operation.
    applyStimulus32(32'd1000, 32'd3, s);
    while (cyc != s + 5) begin
      @(posedge clock); #1;
    end
    rstn32 = 1'b0;
    exp32.delete();
    #1;
    checkOutput("arst_q32", res32, 0);
    checkOutput("arst_r32", rem32, 0);
    checkOutput("arst_busy32", busy32, 0);
    repeat (2) @(negedge clock);
    rstn32 = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    checkOutput("idle_busy32", busy32, 0);
    applyStimulus32(32'd9, 32'd3, s);
    waitDone32();

    @(negedge clock); #1;
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        applyStimulus4(a, b);
        waitDone4();
      end
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
